load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 33 +++
 rtl/load_data_align.sv | 37 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and access checks for the load/store unit
package lsu_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } lsu_state_t;

  // Unsigned variants exist only for loads; halfwords and words must be naturally aligned.
  function automatic logic access_fault(input logic is_store, input logic [2:0] funct3,
                                        input logic [1:0] lane);
    logic fault;
    case (funct3)
      F3_B:    fault = 1'b0;
      F3_BU:   fault = is_store;
      F3_H:    fault = lane[0];
      F3_HU:   fault = is_store | lane[0];
      F3_W:    fault = (lane != 2'b00);
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_data_align.sv
// rtl/load_data_align.sv - load lane select with sign/zero extension
module load_data_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
      F3_W:    result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory-stage load/store unit, one outstanding bus transaction
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [XLEN-1:0]   in_alu_result,
  output logic              lsu_stall,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [BE_W-1:0]   dmem_be,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic              mem_data_select,
  output logic [XLEN-1:0]   alu_result,
  output logic [XLEN-1:0]   data_result,
  output logic              lsu_fault
);

  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   sdata_q;
  logic [XLEN-1:0]   alu_q;
  logic              store_q;

  logic              in_is_mem;
  logic              in_is_store;
  logic              in_fault;
  logic [BE_W-1:0]   be_raw;
  logic [XLEN-1:0]   wdata_raw;
  logic [XLEN-1:0]   load_fmt;

  assign in_is_mem   = in_mem_read | in_mem_write;
  assign in_is_store = in_mem_write & ~in_mem_read;
  assign in_fault    = access_fault(in_is_store, in_funct3, in_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid && in_is_mem && !in_fault) state_nxt = REQ;
      REQ:      if (dmem_req_ready) state_nxt = store_q ? IDLE : WAIT_RSP;
      WAIT_RSP: if (dmem_rsp_valid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Lanes come from the latched request so the bus sees stable values while waiting for ready.
  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = sdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_raw    = 4'b0001 << addr_q[1:0];
        wdata_raw = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        be_raw    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_raw = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign lsu_stall      = (state != IDLE);
  assign dmem_req_valid = (state == REQ);
  assign dmem_we        = dmem_req_valid & store_q;
  assign dmem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_wdata     = wdata_raw;
  assign dmem_be        = dmem_req_valid ? be_raw : '0;

  load_data_align #(.XLEN(XLEN)) u_align (
    .funct3 (funct3_q),
    .lane   (addr_q[1:0]),
    .rdata  (dmem_rdata),
    .result (load_fmt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      funct3_q        <= '0;
      sdata_q         <= '0;
      alu_q           <= '0;
      store_q         <= 1'b0;
      wb_valid        <= 1'b0;
      lsu_fault       <= 1'b0;
      mem_data_select <= 1'b0;
      alu_result      <= '0;
      data_result     <= '0;
    end else begin
      wb_valid  <= 1'b0;
      lsu_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !in_is_mem) begin
            wb_valid        <= 1'b1;
            mem_data_select <= 1'b0;
            alu_result      <= in_alu_result;
          end else if (in_valid) begin
            addr_q    <= in_addr;
            funct3_q  <= in_funct3;
            sdata_q   <= in_store_data;
            alu_q     <= in_alu_result;
            store_q   <= in_is_store;
            lsu_fault <= in_fault;
          end
        end
        REQ: begin
          if (dmem_req_ready && store_q) begin
            wb_valid        <= 1'b1;
            mem_data_select <= 1'b0;
            alu_result      <= alu_q;
          end
        end
        WAIT_RSP: begin
          if (dmem_rsp_valid) begin
            data_result     <= load_fmt;
            wb_valid        <= 1'b1;
            mem_data_select <= 1'b1;
            alu_result      <= alu_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_mem_read, in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_store_data, in_alu_result;
  logic        lsu_stall, dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid;
  logic        wb_valid, mem_data_select, lsu_fault;
  logic [31:0] alu_result, data_result;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data),
    .in_alu_result(in_alu_result), .lsu_stall(lsu_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .mem_data_select(mem_data_select),
    .alu_result(alu_result), .data_result(data_result), .lsu_fault(lsu_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit model_fault(input bit rd, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int size;
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    size  = 1 << f3[1:0];
    return !legal || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] w, v;
    w = rdata >> (8 * a[1:0]);
    case (f3[1:0])
      2'd0: begin
        v = w & 32'hFF;
        if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = w & 32'hFFFF;
        if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int size, lo;
    size = 1 << f3[1:0];
    lo   = int'(a % 4);
    for (int k = 0; k < 4; k++) be[k] = (k >= lo) && (k < lo + size);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w, b;
    int size;
    size = 1 << f3[1:0];
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = (d >> (8 * (k % size))) & 32'hFF;
      w = w | (b << (8 * k));
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic junk_inputs;
    in_valid      = 1'($urandom);
    in_mem_read   = 1'($urandom);
    in_mem_write  = 1'($urandom);
    in_funct3     = 3'($urandom);
    in_addr       = $urandom;
    in_store_data = $urandom;
    in_alu_result = $urandom;
  endtask

  task automatic quiet_inputs;
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
  endtask

  // Caller sits at a negedge with the unit idle; returns at a negedge with the unit idle.
  task automatic do_op(input string nm, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
    bit mem, flt;
    mem = rd || wr;
    flt = mem && model_fault(rd, f3, a);
    in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_funct3 = f3;
    in_addr = a; in_store_data = sd; in_alu_result = alu;
    tick();
    quiet_inputs();
    if (!mem) begin
      check({nm, ".alu_wb"}, 32'(wb_valid), 32'd1);
      check({nm, ".alu_sel"}, 32'(mem_data_select), 32'd0);
      check({nm, ".alu_res"}, alu_result, alu);
      check({nm, ".alu_stall"}, 32'(lsu_stall), 32'd0);
    end else if (flt) begin
      check({nm, ".flt"}, 32'(lsu_fault), 32'd1);
      check({nm, ".flt_wb"}, 32'(wb_valid), 32'd0);
      check({nm, ".flt_req"}, 32'(dmem_req_valid), 32'd0);
      check({nm, ".flt_stall"}, 32'(lsu_stall), 32'd0);
    end else begin
      check({nm, ".req"}, 32'(dmem_req_valid), 32'd1);
      check({nm, ".stall"}, 32'(lsu_stall), 32'd1);
      check({nm, ".addr"}, dmem_addr, a & 32'hFFFF_FFFC);
      check({nm, ".we"}, 32'(dmem_we), 32'(wr));
      if (wr) begin
        check({nm, ".be"}, 32'(dmem_be), 32'(model_be(f3, a)));
        check({nm, ".wdata"}, dmem_wdata, model_wdata(f3, sd));
      end
      for (int i = 0; i < rdy_dly; i++) begin
        junk_inputs();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'($urandom);
        dmem_rdata     = $urandom;
        tick();
        check({nm, ".req_hold"}, 32'(dmem_req_valid), 32'd1);
        check({nm, ".addr_hold"}, dmem_addr, a & 32'hFFFF_FFFC);
        check({nm, ".stall_hold"}, 32'(lsu_stall), 32'd1);
      end
      dmem_req_ready = 1'b1;
      dmem_rsp_valid = 1'b0;
      tick();
      dmem_req_ready = 1'b0;
      if (wr) begin
        check({nm, ".st_wb"}, 32'(wb_valid), 32'd1);
        check({nm, ".st_sel"}, 32'(mem_data_select), 32'd0);
        check({nm, ".st_res"}, alu_result, alu);
        check({nm, ".st_req"}, 32'(dmem_req_valid), 32'd0);
        check({nm, ".st_stall"}, 32'(lsu_stall), 32'd0);
      end else begin
        check({nm, ".ld_wait_wb"}, 32'(wb_valid), 32'd0);
        check({nm, ".ld_wait_stall"}, 32'(lsu_stall), 32'd1);
        check({nm, ".ld_wait_req"}, 32'(dmem_req_valid), 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
          junk_inputs();
          tick();
          check({nm, ".ld_gap_wb"}, 32'(wb_valid), 32'd0);
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
        tick();
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = $urandom;
        check({nm, ".ld_wb"}, 32'(wb_valid), 32'd1);
        check({nm, ".ld_sel"}, 32'(mem_data_select), 32'd1);
        check({nm, ".ld_data"}, data_result, model_load(f3, a, rdata));
        check({nm, ".ld_alu"}, alu_result, alu);
        check({nm, ".ld_stall"}, 32'(lsu_stall), 32'd0);
      end
      quiet_inputs();
    end
    tick();
    check({nm, ".wb_pulse"}, 32'(wb_valid), 32'd0);
    check({nm, ".flt_pulse"}, 32'(lsu_fault), 32'd0);
    check({nm, ".idle_req"}, 32'(dmem_req_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".stall"}, 32'(lsu_stall), 32'd0);
    check({nm, ".req"}, 32'(dmem_req_valid), 32'd0);
    check({nm, ".we"}, 32'(dmem_we), 32'd0);
    check({nm, ".addr"}, dmem_addr, 32'd0);
    check({nm, ".wdata"}, dmem_wdata, 32'd0);
    check({nm, ".be"}, 32'(dmem_be), 32'd0);
    check({nm, ".wb"}, 32'(wb_valid), 32'd0);
    check({nm, ".sel"}, 32'(mem_data_select), 32'd0);
    check({nm, ".alu"}, alu_result, 32'd0);
    check({nm, ".data"}, data_result, 32'd0);
    check({nm, ".flt"}, 32'(lsu_fault), 32'd0);
  endtask

  initial begin
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;

    rst_n = 1'b0;
    quiet_inputs();
    in_funct3 = '0; in_addr = '0; in_store_data = '0; in_alu_result = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("alu", 0, 0, 3'd0, 32'h0, 32'h0, 32'h1234_5678, 0, 0, 32'h0);
    do_op("lb", 1, 0, 3'b000, 32'h1003, 32'h0, 32'hA5A5_0001, 0, 0, 32'h80AB_CD12);
    do_op("lhu", 1, 0, 3'b101, 32'h2002, 32'h0, 32'h0000_0002, 3, 1, 32'hBEEF_1234);
    do_op("sh", 0, 1, 3'b001, 32'h0006, 32'h0000_ABCD, 32'h0000_0003, 0, 0, 32'h0);
    do_op("lw_mis", 1, 0, 3'b010, 32'h1001, 32'h0, 32'h0000_0004, 0, 0, 32'h0);
    do_op("sbu_ill", 0, 1, 3'b100, 32'h1000, 32'h0, 32'h0000_0005, 0, 0, 32'h0);
    do_op("lw", 1, 0, 3'b010, 32'h4000, 32'h0, 32'h0000_0006, 1, 2, 32'hCAFE_F00D);

    // Reset while waiting for a load response: the late response must not complete it.
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
    in_funct3 = 3'b010; in_addr = 32'h3000; in_alu_result = 32'h77;
    tick();
    quiet_inputs();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check("rstw.pre_stall", 32'(lsu_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("rstw");
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'h1111_2222;
    tick();
    dmem_rsp_valid = 1'b0;
    check("rstw.late_wb", 32'(wb_valid), 32'd0);
    check("rstw.late_data", data_result, 32'd0);
    check("rstw.late_stall", 32'(lsu_stall), 32'd0);
    tick();
    check("rstw.late_wb2", 32'(wb_valid), 32'd0);

    // Reset while the request is on the bus drops req_valid without waiting for a clock.
    in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b1;
    in_funct3 = 3'b010; in_addr = 32'h5000; in_store_data = 32'h55;
    tick();
    quiet_inputs();
    check("rstq.pre_req", 32'(dmem_req_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstq.req", 32'(dmem_req_valid), 32'd0);
    check("rstq.be", 32'(dmem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 3));
      rd = 1'b0; wr = 1'b0;
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      case (kind)
        0: ;
        1: begin rd = 1'b1; if (f3 inside {3'd3, 3'd6, 3'd7}) f3 = 3'd2; end
        2: begin wr = 1'b1; if (f3 > 3'd2) f3 = 3'(f3 % 3); end
        default: if ($urandom_range(0, 1) == 1) rd = 1'b1; else wr = 1'b1;
      endcase
      do_op("rnd", rd, wr, f3, a, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
